// File: rtl/regfile_wb_arbiter_if.sv
// Writeback / scoreboard bus between the pipeline and the regfile write-port arbiter.
// Master drives requests, allocations and queries; slave returns grants, busy bits and the regfile write.
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              s0_valid;
  logic              s0_ready;
  logic [ADDR_W-1:0] s0_addr;
  logic [DATA_W-1:0] s0_data;
  logic              s1_valid;
  logic              s1_ready;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_data;
  logic              alloc_en;
  logic [ADDR_W-1:0] alloc_addr;
  logic              flush;
  logic [ADDR_W-1:0] q1_addr;
  logic              q1_busy;
  logic [ADDR_W-1:0] q2_addr;
  logic              q2_busy;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output alloc_en, alloc_addr, flush, q1_addr, q2_addr,
    input  s0_ready, s1_ready, q1_busy, q2_busy,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  alloc_en, alloc_addr, flush, q1_addr, q2_addr,
    output s0_ready, s1_ready, q1_busy, q2_busy,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port (ALU vs load writeback),
// with a one-cycle registered write stage and a pending-write scoreboard for decode.

// One scoreboard bit: flush beats alloc, alloc beats commit (newest producer wins).
module regfile_wb_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic i_flush,
  input  logic i_set,
  input  logic i_clr,
  output logic o_pend
);
  logic r_pend;

  always_ff @(posedge clk) begin
    if (rst || i_flush) r_pend <= 1'b0;
    else if (i_set)     r_pend <= 1'b1;
    else if (i_clr)     r_pend <= 1'b0;
  end

  assign o_pend = r_pend;
endmodule

module regfile_wb_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);
  logic              r_rr_ptr;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [DATA_W-1:0] r_rf_wdata;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any_gnt;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_wr_en;
  logic [NUM_REGS-1:0] w_pending;

  // r_rr_ptr only matters on contention; a lone requester always wins.
  assign w_gnt0     = !rst && bus.s0_valid && (!bus.s1_valid || !r_rr_ptr);
  assign w_gnt1     = !rst && bus.s1_valid && (!bus.s0_valid ||  r_rr_ptr);
  assign w_any_gnt  = w_gnt0 || w_gnt1;
  assign w_sel_addr = w_gnt1 ? bus.s1_addr : bus.s0_addr;
  assign w_sel_data = w_gnt1 ? bus.s1_data : bus.s0_data;
  assign w_wr_en    = w_any_gnt && (w_sel_addr != '0);

  assign bus.s0_ready = w_gnt0;
  assign bus.s1_ready = w_gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else begin
      if (w_gnt0)      r_rr_ptr <= 1'b1;
      else if (w_gnt1) r_rr_ptr <= 1'b0;
      r_rf_we <= w_wr_en;
      // x0 writes are swallowed: address/data keep the last real write
      if (w_wr_en) begin
        r_rf_waddr <= w_sel_addr;
        r_rf_wdata <= w_sel_data;
      end
    end
  end

  assign bus.rf_we    = r_rf_we;
  assign bus.rf_waddr = r_rf_waddr;
  assign bus.rf_wdata = r_rf_wdata;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    if (g == 0) begin : g_x0
      assign w_pending[g] = 1'b0;
    end else begin : g_reg
      regfile_wb_pend_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_set   (bus.alloc_en && (bus.alloc_addr == ADDR_W'(g))),
        .i_clr   (r_rf_we && (r_rf_waddr == ADDR_W'(g))),
        .o_pend  (w_pending[g])
      );
    end
  end

  // A write landing this cycle is forwarded by the regfile, so it no longer stalls decode.
  assign bus.q1_busy = !rst && w_pending[bus.q1_addr] &&
                       !(r_rf_we && (r_rf_waddr == bus.q1_addr));
  assign bus.q2_busy = !rst && w_pending[bus.q2_addr] &&
                       !(r_rf_we && (r_rf_waddr == bus.q2_addr));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed literal cases, then randomized traffic
// checked every cycle against a behavioural model of grants, writes and pending bits.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NREG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          pm [NREG];
  bit          rr_m, we_m, known_m, ok_m;
  logic [4:0]  wa_m;
  logic [31:0] wd_m;
  bit          pm_n [NREG];
  bit          rr_n, we_n, known_n, ok_n;
  logic [4:0]  wa_n;
  logic [31:0] wd_n;

  function automatic bit exp_busy(input logic [4:0] q);
    return !rst && pm[q] && !(we_m && wa_m == q);
  endfunction

  always @(negedge clk) begin
    bit g0, g1;
    logic [4:0]  ga;
    logic [31:0] gd;
    if (rst) begin
      g0 = 0; g1 = 0;
    end else if (bus.s0_valid && bus.s1_valid) begin
      g0 = !rr_m; g1 = rr_m;
    end else begin
      g0 = bus.s0_valid; g1 = bus.s1_valid;
    end
    ga = g1 ? bus.s1_addr : bus.s0_addr;
    gd = g1 ? bus.s1_data : bus.s0_data;

    if (ok_m) begin
      chk("s0_ready", 64'(bus.s0_ready), 64'(g0));
      chk("s1_ready", 64'(bus.s1_ready), 64'(g1));
      chk("q1_busy", 64'(bus.q1_busy), 64'(exp_busy(bus.q1_addr)));
      chk("q2_busy", 64'(bus.q2_busy), 64'(exp_busy(bus.q2_addr)));
      chk("rf_we", 64'(bus.rf_we), 64'(we_m));
      if (known_m) begin
        chk("rf_waddr", 64'(bus.rf_waddr), 64'(wa_m));
        chk("rf_wdata", 64'(bus.rf_wdata), 64'(wd_m));
      end
    end

    if (rst) begin
      foreach (pm_n[i]) pm_n[i] = 0;
      rr_n = 0; we_n = 0; wa_n = 0; wd_n = 0; known_n = 1; ok_n = 1;
    end else begin
      ok_n = ok_m;
      rr_n = g0 ? 1'b1 : (g1 ? 1'b0 : rr_m);
      we_n = (g0 || g1) && ga != 0;
      wa_n = wa_m; wd_n = wd_m; known_n = known_m;
      if (g0 || g1) begin
        if (ga != 0) begin wa_n = ga; wd_n = gd; known_n = 1; end
        else known_n = 0;
      end
      foreach (pm_n[i]) begin
        pm_n[i] = pm[i];
        if (we_m && wa_m == i) pm_n[i] = 0;
        if (bus.alloc_en && bus.alloc_addr == i && i != 0) pm_n[i] = 1;
        if (bus.flush) pm_n[i] = 0;
      end
    end
  end

  always @(posedge clk) begin
    pm <= pm_n; rr_m <= rr_n; we_m <= we_n; wa_m <= wa_n; wd_m <= wd_n;
    known_m <= known_n; ok_m <= ok_n;
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    bus.s0_valid = 0; bus.s0_addr = 0; bus.s0_data = 0;
    bus.s1_valid = 0; bus.s1_addr = 0; bus.s1_data = 0;
    bus.alloc_en = 0; bus.alloc_addr = 0; bus.flush = 0;
    bus.q1_addr = 0; bus.q2_addr = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; idle();
    step(); step();
    rst = 0;
  endtask

  initial begin
    ok_n = 0; ok_m = 0;
    idle();
    do_reset();

    // single ALU write
    bus.s0_valid = 1; bus.s0_addr = 3; bus.s0_data = 32'h1111_1111;
    @(negedge clk); chk("t1_ready", 64'(bus.s0_ready), 64'd1);
    step(); idle();
    @(negedge clk);
    chk("t1_we", 64'(bus.rf_we), 64'd1);
    chk("t1_waddr", 64'(bus.rf_waddr), 64'd3);
    chk("t1_wdata", 64'(bus.rf_wdata), 64'h1111_1111);
    step();
    @(negedge clk); chk("t1_we_off", 64'(bus.rf_we), 64'd0);

    // alternating grants under contention
    do_reset();
    bus.s0_valid = 1; bus.s0_addr = 1; bus.s0_data = 32'hA;
    bus.s1_valid = 1; bus.s1_addr = 2; bus.s1_data = 32'hB;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_s0_ready", 64'(bus.s0_ready), 64'(k % 2 == 0));
      chk("t2_s1_ready", 64'(bus.s1_ready), 64'(k % 2 == 1));
      if (k > 0) chk("t2_waddr", 64'(bus.rf_waddr), (k % 2 == 1) ? 64'd1 : 64'd2);
      step();
    end
    idle();

    // write to x0 is accepted but not performed
    bus.s1_valid = 1; bus.s1_addr = 0; bus.s1_data = 32'hFFFF_FFFF;
    @(negedge clk); chk("t3_ready", 64'(bus.s1_ready), 64'd1);
    step(); idle();
    @(negedge clk); chk("t3_we", 64'(bus.rf_we), 64'd0);
    step();

    // alloc then commit clears busy in the write cycle
    bus.alloc_en = 1; bus.alloc_addr = 5; bus.q1_addr = 5;
    @(negedge clk); chk("t4_busy0", 64'(bus.q1_busy), 64'd0);
    step(); bus.alloc_en = 0;
    @(negedge clk); chk("t4_busy1", 64'(bus.q1_busy), 64'd1);
    step(); bus.s0_valid = 1; bus.s0_addr = 5; bus.s0_data = 32'h55;
    @(negedge clk); chk("t4_busy2", 64'(bus.q1_busy), 64'd1);
    step(); bus.s0_valid = 0;
    @(negedge clk);
    chk("t4_we", 64'(bus.rf_we), 64'd1);
    chk("t4_busy3", 64'(bus.q1_busy), 64'd0);
    step();
    @(negedge clk); chk("t4_busy4", 64'(bus.q1_busy), 64'd0);
    step();

    // same-cycle alloc + commit keeps pending; flush clears it
    bus.s0_valid = 1; bus.s0_addr = 7; bus.s0_data = 32'h77; bus.q2_addr = 7;
    step(); bus.s0_valid = 0; bus.alloc_en = 1; bus.alloc_addr = 7;
    @(negedge clk); chk("t5_we", 64'(bus.rf_we), 64'd1);
    step(); bus.alloc_en = 0; bus.flush = 1;
    @(negedge clk); chk("t5_busy_kept", 64'(bus.q2_busy), 64'd1);
    step(); bus.flush = 0;
    @(negedge clk); chk("t5_busy_flushed", 64'(bus.q2_busy), 64'd0);
    step();

    // reset right after a granted transfer
    bus.alloc_en = 1; bus.alloc_addr = 9; bus.q1_addr = 9;
    step(); bus.alloc_en = 0;
    bus.s1_valid = 1; bus.s1_addr = 4; bus.s1_data = 32'h44;
    step(); bus.s1_valid = 0; rst = 1;
    @(negedge clk);
    chk("t6_rst_q1", 64'(bus.q1_busy), 64'd0);
    chk("t6_rst_ready", 64'(bus.s0_ready), 64'd0);
    step(); rst = 0;
    bus.s0_valid = 1; bus.s0_addr = 6; bus.s0_data = 32'h66;
    bus.s1_valid = 1; bus.s1_addr = 8; bus.s1_data = 32'h88;
    @(negedge clk);
    chk("t6_we", 64'(bus.rf_we), 64'd0);
    chk("t6_busy", 64'(bus.q1_busy), 64'd0);
    chk("t6_s0_first", 64'(bus.s0_ready), 64'd1);
    step(); idle();

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      bit x0, x1;
      @(negedge clk);
      x0 = bus.s0_valid && bus.s0_ready;
      x1 = bus.s1_valid && bus.s1_ready;
      step();
      rst = ($urandom_range(0, 149) == 0);
      if (!bus.s0_valid || x0) begin
        bus.s0_valid = ($urandom_range(0, 2) != 0);
        bus.s0_addr  = 5'($urandom_range(0, 7));
        bus.s0_data  = $urandom;
      end
      if (!bus.s1_valid || x1) begin
        bus.s1_valid = ($urandom_range(0, 2) != 0);
        bus.s1_addr  = 5'($urandom_range(0, 7));
        bus.s1_data  = $urandom;
      end
      bus.alloc_en   = ($urandom_range(0, 2) == 0);
      bus.alloc_addr = 5'($urandom_range(0, 7));
      bus.flush      = ($urandom_range(0, 39) == 0);
      bus.q1_addr    = 5'($urandom_range(0, 7));
      bus.q2_addr    = 5'($urandom_range(0, 31));
    end
    rst = 0; idle();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Owns the single register-file write port. Shares it between two writeback requesters (s0 = ALU/EX result, s1 = load/MEM result) using round-robin arbitration. Registers the winning write for one cycle and drives the regfile we/waddr/wdata inputs. Also keeps a pending-write scoreboard, so decode can stall on source registers whose producer has not yet written back.

Parameters:
DATA_W, 32, register data width (matches the regfile data bus)
ADDR_W, 5, register address width
NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W

Ports:
clk  input  1  system clock, all state updates on posedge
rst  input  1  synchronous reset, active-high
s0_valid  input  1  ALU writeback request
s0_ready  output  1  ALU request granted this cycle
s0_addr  input  ADDR_W  ALU destination register
s0_data  input  DATA_W  ALU result
s1_valid  input  1  load writeback request
s1_ready  output  1  load request granted this cycle
s1_addr  input  ADDR_W  load destination register
s1_data  input  DATA_W  load data
alloc_en  input  1  decode issued an instruction that writes rd
alloc_addr  input  ADDR_W  rd being reserved
flush  input  1  pipeline flush; clears the scoreboard
q1_addr  input  ADDR_W  decode source-register query 1
q1_busy  output  1  q1_addr has an outstanding write
q2_addr  input  ADDR_W  decode source-register query 2
q2_busy  output  1  q2_addr has an outstanding write
rf_we  output  1  regfile write enable
rf_waddr  output  ADDR_W  regfile write address
rf_wdata  output  DATA_W  regfile write data

Behaviour:
- Reset is synchronous and active-high: while rst=1 at posedge, the following are cleared:
  - pending[NUM_REGS-1:0]=0, rr_ptr=0 (s0 preferred)
  - rf_we=0, rf_waddr=0, rf_wdata=0
- While rst=1, s0_ready=s1_ready=0 and q1_busy=q2_busy=0.
- A reset asserted mid-operation discards the registered write: rf_we=0 on the next cycle.
- Arbitration is combinational each cycle:
  - only s0_valid: grant s0;
  - only s1_valid: grant s1;
  - both valid: grant s0 if rr_ptr=0, else s1;
  - none valid: no grant.
- sX_ready equals the grant; at most one ready is high per cycle. A transfer is sX_valid & sX_ready.
- rr_ptr update: after granting s0, rr_ptr<=1; after granting s1, rr_ptr<=0; with no grant it holds.
- Requesters hold valid/addr/data stable until ready; a denied request waits at most one cycle when the other source is continuously valid.
- Output stage:
  - Latency is exactly 1 cycle: a transfer at cycle N produces rf_we=1 with the granted addr/data at cycle N+1.
  - No transfer at N gives rf_we=0 at N+1; rf_waddr/rf_wdata hold their last values.
  - A transfer with addr=0 is accepted (ready=1) but gives rf_we=0 at N+1.
- Scoreboard:
  - alloc_en with alloc_addr!=0 sets pending[alloc_addr] at the posedge; alloc to x0 is ignored.
  - Commit: rf_we=1 at the posedge clears pending[rf_waddr].
  - Alloc and commit to the same register in the same cycle leaves pending=1, because the new producer wins.
  - flush clears all pending bits. flush has priority over a same-cycle alloc and does not cancel an in-flight rf_we.
- Query (combinational): qX_busy = pending[qX_addr] & !(rf_we & rf_waddr==qX_addr). The regfile's same-cycle write bypass supplies the data in the excluded case. qX_addr=0 always gives busy=0.
- pending is not double-counted: a second alloc to a register already pending keeps it at 1 and the first commit clears it. Decode must therefore not issue WAW to a pending register; that rule is enforced outside this block.

Test Plan:
- Reset, then s0_valid=1, addr=3, data=0x11111111 for one cycle -> s0_ready=1 that cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x11111111; the cycle after, rf_we=0.
- Both sources valid continuously (s0 addr=1 data=0xA, s1 addr=2 data=0xB) from reset -> grants alternate s0,s1,s0,s1; rf_waddr sequence 1,2,1,2 with 1-cycle lag.
- s1_valid with addr=0, data=0xFFFFFFFF -> s1_ready=1; next cycle rf_we=0.
- alloc_en addr=5, q1_addr=5 -> q1_busy=1 from the next cycle. s0 writes reg 5 -> q1_busy=0 in the rf_we cycle, and pending[5]=0 afterwards.
- alloc_en addr=7 in the same cycle that rf_we=1, rf_waddr=7 -> pending[7]=1 afterwards. flush one cycle later -> q2_addr=7 gives q2_busy=0.
- rst asserted the cycle after a granted transfer -> rf_we=0 and all busy=0 next cycle. After release, both valid -> s0 granted first.
